fb_loop_sequencer: RTL and testbench

- Timing and mode controller for the FOG closed-loop feedback step generator.
- Derives the per-modulation-period accumulate strobe (o_trig) and update strobe (o_trig_dly) from a free-running period counter.
- Sequences loop mode: off / constant-step / closed-loop.
- In closed-loop mode, schedules the right-shift gain: coarse gain during acquisition, fine gain once the error is locked.

---
 rtl/fb_loop_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_fb_loop_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_loop_sequencer.sv
// fb_loop_sequencer
// Timing and mode controller for the FOG closed-loop feedback step generator.
// A free-running period counter produces the per-period accumulate strobe
// (o_trig) and the delayed step-update strobe (o_trig_dly). A small FSM
// sequences the loop mode (off / constant-step / closed-loop) and, while the
// loop is closed, schedules the right-shift gain: coarse while acquiring,
// fine once the demodulated error has stayed inside the lock window.
//
// Optional feature: define FB_SEQ_TIMEOUT_EN to enable the acquisition
// timeout (o_fault plus fallback to constant-step). Without it o_fault is 0
// and acquisition may last indefinitely.
//
// Parameters:
//   PERIOD_W      width of the period counter and timing configuration
//   TRIG_DLY      clocks from o_trig to o_trig_dly (1..4)
//   GAIN_RST      gain reported outside closed-loop and at reset
//   TIMEOUT_TRIGS o_trig count in acquisition before the timeout fires
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_mode          0 off, 1 closed-loop, 2 const-step, 3 off
//   i_period        clocks per modulation period (sampled at each wrap)
//   i_trig_ofs      counter value at which o_trig is scheduled
//   i_err           signed demodulated error, valid while o_trig_dly is high
//   i_gain_coarse   shift used while acquiring
//   i_gain_fine     shift used while tracking
//   i_lock_thr      |err| below this counts toward lock
//   i_unlock_thr    |err| above this drops tracking back to acquisition
//   i_lock_cnt      consecutive in-window updates needed for lock (0 => 1)
//   o_trig          accumulate strobe, one clock per period
//   o_trig_dly      step-update strobe, TRIG_DLY clocks after o_trig
//   o_fb_ON         mode word to the step generator (0 off, 1 loop, 2 const)
//   o_gain_sel      shift amount, zero-extended
//   o_state         0 IDLE, 1 CONST, 2 ACQ, 3 TRACK
//   o_locked        high while tracking
//   o_cfg_err       sticky: trigger offset outside the period or period too short
//   o_fault         sticky acquisition timeout (optional feature only)

module fb_loop_sequencer #(
  parameter int PERIOD_W      = 16,
  parameter int TRIG_DLY      = 1,
  parameter int GAIN_RST      = 5,
  parameter int TIMEOUT_TRIGS = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_mode,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [PERIOD_W-1:0] i_trig_ofs,
  input  logic [31:0]         i_err,
  input  logic [4:0]          i_gain_coarse,
  input  logic [4:0]          i_gain_fine,
  input  logic [30:0]         i_lock_thr,
  input  logic [30:0]         i_unlock_thr,
  input  logic [7:0]          i_lock_cnt,
  output logic                o_trig,
  output logic                o_trig_dly,
  output logic [31:0]         o_fb_ON,
  output logic [31:0]         o_gain_sel,
  output logic [1:0]          o_state,
  output logic                o_locked,
  output logic                o_cfg_err,
  output logic                o_fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONST = 2'd1,
    ST_ACQ   = 2'd2,
    ST_TRACK = 2'd3
  } state_t;

  localparam logic [4:0]          GAIN_RST_V = 5'(GAIN_RST);
  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(TRIG_DLY + 2);
  localparam logic [15:0]         TO_LAST    = 16'(TIMEOUT_TRIGS - 1);

  // ---------------------------------------------------------------------
  // Period counter and shadowed timing configuration
  // ---------------------------------------------------------------------
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_sh;
  logic [PERIOD_W-1:0] ofs_sh;
  logic                loaded;
  logic [PERIOD_W-1:0] eff_period;
  logic [PERIOD_W-1:0] eff_ofs;
  logic                wrap;
  logic                cfg_bad;
  logic                trig_q;
  logic                cfg_err_q;
  logic [TRIG_DLY-1:0] dly_sr;

  // In the first cycle after reset release the shadows are still empty, so
  // the live inputs stand in for them; that cycle is also when they load.
  assign eff_period = loaded ? period_sh : i_period;
  assign eff_ofs    = loaded ? ofs_sh    : i_trig_ofs;
  assign wrap       = (cnt == eff_period - PERIOD_W'(1));
  assign cfg_bad    = (eff_ofs >= eff_period) || (eff_period < MIN_PERIOD);

  // Counter, shadows, accumulate strobe and sticky configuration error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      period_sh <= '0;
      ofs_sh    <= '0;
      loaded    <= 1'b0;
      trig_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      loaded <= 1'b1;
      if (!loaded || wrap) begin
        period_sh <= i_period;
        ofs_sh    <= i_trig_ofs;
      end
      cnt    <= wrap ? '0 : cnt + PERIOD_W'(1);
      trig_q <= (cnt == eff_ofs) && !cfg_bad;
      if (cfg_bad) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  // Update strobe: o_trig delayed through a TRIG_DLY-deep shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dly_sr <= '0;
    end else begin
      dly_sr[0] <= trig_q;
      for (int i = 1; i < TRIG_DLY; i++) begin
        dly_sr[i] <= dly_sr[i-1];
      end
    end
  end

  assign o_trig     = trig_q;
  assign o_trig_dly = dly_sr[TRIG_DLY-1];
  assign o_cfg_err  = cfg_err_q;

  // ---------------------------------------------------------------------
  // Error magnitude and lock bookkeeping
  // ---------------------------------------------------------------------
  logic [31:0] err_abs;
  logic [31:0] lock_thr_ext;
  logic [31:0] unlock_thr_ext;
  logic [7:0]  lock_cnt;
  logic [7:0]  lock_inc;
  logic [7:0]  lock_req;

  // -2^31 has no positive counterpart, so it saturates to 2^31-1.
  always_comb begin
    if (i_err == 32'h8000_0000) begin
      err_abs = 32'h7FFF_FFFF;
    end else if (i_err[31]) begin
      err_abs = (~i_err) + 32'd1;
    end else begin
      err_abs = i_err;
    end
  end

  assign lock_thr_ext   = {1'b0, i_lock_thr};
  assign unlock_thr_ext = {1'b0, i_unlock_thr};
  assign lock_inc       = (lock_cnt == 8'hFF) ? 8'hFF : lock_cnt + 8'd1;
  assign lock_req       = (i_lock_cnt == 8'd0) ? 8'd1 : i_lock_cnt;

  // ---------------------------------------------------------------------
  // Acquisition timeout (optional)
  // ---------------------------------------------------------------------
  state_t state;
  logic   fault_q;

`ifdef FB_SEQ_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Counts accumulate strobes spent in ACQ; reaching the limit latches the
  // fault, which keeps the loop in constant-step until mode 0 is applied.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      to_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state != ST_ACQ) begin
        to_cnt <= '0;
      end else if (trig_q && (to_cnt != 16'hFFFF)) begin
        to_cnt <= to_cnt + 16'd1;
      end
      if (i_mode == 2'd0) begin
        fault_q <= 1'b0;
      end else if ((state == ST_ACQ) && trig_q && (to_cnt == TO_LAST)) begin
        fault_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LAST;
  assign fault_q        = 1'b0;
`endif

  assign o_fault = fault_q;

  // ---------------------------------------------------------------------
  // Mode / gain FSM
  // ---------------------------------------------------------------------
  state_t     mode_target;
  logic       mode_change;
  logic [1:0] fb_on_q;
  logic       locked_q;
  logic [4:0] gain_q;

  function automatic logic [1:0] fb_code(input state_t s);
    case (s)
      ST_CONST:        fb_code = 2'd2;
      ST_ACQ, ST_TRACK: fb_code = 2'd1;
      default:         fb_code = 2'd0;
    endcase
  endfunction

  // Where the requested mode would take the FSM; only acted on at a wrap.
  // Staying in closed-loop keeps ACQ/TRACK, so it is not a mode change.
  always_comb begin
    mode_target = state;
    case (i_mode)
      2'd1: begin
        if (fault_q) begin
          mode_target = ST_CONST;
        end else if ((state == ST_IDLE) || (state == ST_CONST)) begin
          mode_target = ST_ACQ;
        end
      end
      2'd2:    mode_target = ST_CONST;
      default: mode_target = ST_IDLE;
    endcase
  end

  assign mode_change = wrap && (mode_target != state);

  // Mode changes happen only at the wrap and take priority over a lock
  // evaluation in the same cycle. The gain register follows the state with
  // one cycle of lag, so a new gain is first used at the next period's update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      lock_cnt <= '0;
      fb_on_q  <= 2'd0;
      locked_q <= 1'b0;
      gain_q   <= GAIN_RST_V;
    end else begin
      case (state)
        ST_ACQ:   gain_q <= i_gain_coarse;
        ST_TRACK: gain_q <= i_gain_fine;
        default:  gain_q <= GAIN_RST_V;
      endcase

      if (mode_change) begin
        state    <= mode_target;
        lock_cnt <= '0;
        fb_on_q  <= fb_code(mode_target);
        locked_q <= (mode_target == ST_TRACK);
      end else if (o_trig_dly && (state == ST_ACQ)) begin
        if (err_abs < lock_thr_ext) begin
          if (lock_inc >= lock_req) begin
            state    <= ST_TRACK;
            lock_cnt <= '0;
            locked_q <= 1'b1;
          end else begin
            lock_cnt <= lock_inc;
          end
        end else begin
          lock_cnt <= '0;
        end
      end else if (o_trig_dly && (state == ST_TRACK)) begin
        if (err_abs > unlock_thr_ext) begin
          state    <= ST_ACQ;
          lock_cnt <= '0;
          locked_q <= 1'b0;
        end
      end
    end
  end

  assign o_state    = state;
  assign o_fb_ON    = {30'd0, fb_on_q};
  assign o_locked   = locked_q;
  assign o_gain_sel = {27'd0, gain_q};

endmodule

// File: tb/tb_fb_loop_sequencer.sv
// Directed self-checking bench for fb_loop_sequencer. Time is tracked as
// the number of rising edges since reset release (cyc); during the cycle
// after edge k the period counter holds k modulo the current period.

module tb_fb_loop_sequencer;

  logic        i_clk;
  logic        i_rst_n;
  logic [1:0]  i_mode;
  logic [15:0] i_period;
  logic [15:0] i_trig_ofs;
  logic [31:0] i_err;
  logic [4:0]  i_gain_coarse;
  logic [4:0]  i_gain_fine;
  logic [30:0] i_lock_thr;
  logic [30:0] i_unlock_thr;
  logic [7:0]  i_lock_cnt;
  logic        o_trig;
  logic        o_trig_dly;
  logic [31:0] o_fb_ON;
  logic [31:0] o_gain_sel;
  logic [1:0]  o_state;
  logic        o_locked;
  logic        o_cfg_err;
  logic        o_fault;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fb_loop_sequencer #(
    .PERIOD_W(16), .TRIG_DLY(1), .GAIN_RST(5), .TIMEOUT_TRIGS(8)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_mode(i_mode), .i_period(i_period),
    .i_trig_ofs(i_trig_ofs), .i_err(i_err), .i_gain_coarse(i_gain_coarse),
    .i_gain_fine(i_gain_fine), .i_lock_thr(i_lock_thr),
    .i_unlock_thr(i_unlock_thr), .i_lock_cnt(i_lock_cnt), .o_trig(o_trig),
    .o_trig_dly(o_trig_dly), .o_fb_ON(o_fb_ON), .o_gain_sel(o_gain_sel),
    .o_state(o_state), .o_locked(o_locked), .o_cfg_err(o_cfg_err),
    .o_fault(o_fault)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic release_reset();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_mode = 2'd0; i_period = 16'd100; i_trig_ofs = 16'd10;
    i_err = 32'd5000; i_gain_coarse = 5'd3; i_gain_fine = 5'd8;
    i_lock_thr = 31'd100; i_unlock_thr = 31'd1000; i_lock_cnt = 8'd4;
    #12;
    checks++; if (o_trig !== 1'b0) begin failures++; $display("[TB] FAIL rst_trig: got %0d expected 0", o_trig); end
    checks++; if (o_trig_dly !== 1'b0) begin failures++; $display("[TB] FAIL rst_trig_dly: got %0d expected 0", o_trig_dly); end
    checks++; if (o_fb_ON !== 32'd0) begin failures++; $display("[TB] FAIL rst_fb_on: got %0d expected 0", o_fb_ON); end
    checks++; if (o_gain_sel !== 32'd5) begin failures++; $display("[TB] FAIL rst_gain: got %0d expected 5", o_gain_sel); end
    checks++; if (o_state !== 2'd0) begin failures++; $display("[TB] FAIL rst_state: got %0d expected 0", o_state); end
    checks++; if (o_locked !== 1'b0) begin failures++; $display("[TB] FAIL rst_locked: got %0d expected 0", o_locked); end
    checks++; if (o_cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL rst_cfg_err: got %0d expected 0", o_cfg_err); end
    checks++; if (o_fault !== 1'b0) begin failures++; $display("[TB] FAIL rst_fault: got %0d expected 0", o_fault); end
    release_reset();
  endtask

  // P=100, ofs=10: o_trig at cnt 11, o_trig_dly at cnt 12. A mid-period
  // change of i_period to 50 applies only from the wrap at edge 100.
  task automatic test_strobes();
    int n;
    go_to(11);
    checks++; if (o_trig !== 1'b1) begin failures++; $display("[TB] FAIL trig_at_11: got %0d expected 1", o_trig); end
    checks++; if (o_trig_dly !== 1'b0) begin failures++; $display("[TB] FAIL dly_at_11: got %0d expected 0", o_trig_dly); end
    go_to(12);
    checks++; if (o_trig !== 1'b0) begin failures++; $display("[TB] FAIL trig_at_12: got %0d expected 0", o_trig); end
    checks++; if (o_trig_dly !== 1'b1) begin failures++; $display("[TB] FAIL dly_at_12: got %0d expected 1", o_trig_dly); end
    go_to(13);
    checks++; if (o_trig_dly !== 1'b0) begin failures++; $display("[TB] FAIL dly_at_13: got %0d expected 0", o_trig_dly); end
    i_period = 16'd50;
    n = 0;
    while (cyc < 110) begin tick(); n += int'(o_trig); end
    checks++; if (n != 0) begin failures++; $display("[TB] FAIL no_trig_mid_change: got %0d pulses expected 0", n); end
    go_to(111);
    checks++; if (o_trig !== 1'b1) begin failures++; $display("[TB] FAIL trig_at_111: got %0d expected 1", o_trig); end
    go_to(112);
    checks++; if (o_trig_dly !== 1'b1) begin failures++; $display("[TB] FAIL dly_at_112: got %0d expected 1", o_trig_dly); end
    n = 0;
    while (cyc < 160) begin tick(); n += int'(o_trig); end
    checks++; if (n != 0) begin failures++; $display("[TB] FAIL no_trig_p50: got %0d pulses expected 0", n); end
    go_to(161);
    checks++; if (o_trig !== 1'b1) begin failures++; $display("[TB] FAIL trig_at_161: got %0d expected 1", o_trig); end
    checks++; if (o_fb_ON !== 32'd0) begin failures++; $display("[TB] FAIL idle_fb_on: got %0d expected 0", o_fb_ON); end
  endtask

  // Mode 1 requested mid-period takes effect at the wrap at edge 200.
  task automatic test_mode_enter();
    go_to(170);
    i_mode = 2'd1;
    go_to(199);
    checks++; if (o_fb_ON !== 32'd0) begin failures++; $display("[TB] FAIL pre_wrap_fb_on: got %0d expected 0", o_fb_ON); end
    checks++; if (o_state !== 2'd0) begin failures++; $display("[TB] FAIL pre_wrap_state: got %0d expected 0", o_state); end
    go_to(200);
    checks++; if (o_state !== 2'd2) begin failures++; $display("[TB] FAIL acq_state: got %0d expected 2", o_state); end
    checks++; if (o_fb_ON !== 32'd1) begin failures++; $display("[TB] FAIL acq_fb_on: got %0d expected 1", o_fb_ON); end
    checks++; if (o_gain_sel !== 32'd5) begin failures++; $display("[TB] FAIL acq_gain_lag: got %0d expected 5", o_gain_sel); end
    go_to(201);
    checks++; if (o_gain_sel !== 32'd3) begin failures++; $display("[TB] FAIL acq_gain: got %0d expected 3", o_gain_sel); end
  endtask

  // Errors per period 50,200,50,50,50,50 with thr=100, cnt=4: the 200
  // clears the run, so TRACK is reached only after the sixth update.
  task automatic test_lock();
    int errs[6] = '{50, 200, 50, 50, 50, 50};
    for (int j = 0; j < 6; j++) begin
      go_to(201 + 50 * j);
      i_err = 32'(errs[j]);
      go_to(213 + 50 * j);
      if (j < 5) begin
        checks++; if (o_state !== 2'd2) begin failures++; $display("[TB] FAIL lock_run_%0d: state %0d expected 2", j, o_state); end
      end else begin
        checks++; if (o_state !== 2'd3) begin failures++; $display("[TB] FAIL lock_reached: state %0d expected 3", o_state); end
        checks++; if (o_locked !== 1'b1) begin failures++; $display("[TB] FAIL lock_flag: got %0d expected 1", o_locked); end
        checks++; if (o_gain_sel !== 32'd3) begin failures++; $display("[TB] FAIL track_gain_lag: got %0d expected 3", o_gain_sel); end
      end
    end
    go_to(464);
    checks++; if (o_gain_sel !== 32'd8) begin failures++; $display("[TB] FAIL track_gain: got %0d expected 8", o_gain_sel); end
  endtask

  // unlock_thr=1000: -999 and +1000 keep TRACK, -2^31 saturates and drops.
  task automatic test_unlock();
    go_to(501); i_err = -32'sd999;
    go_to(513);
    checks++; if (o_state !== 2'd3) begin failures++; $display("[TB] FAIL hold_m999: state %0d expected 3", o_state); end
    go_to(551); i_err = 32'd1000;
    go_to(563);
    checks++; if (o_state !== 2'd3) begin failures++; $display("[TB] FAIL hold_1000: state %0d expected 3", o_state); end
    go_to(601); i_err = 32'h8000_0000;
    go_to(613);
    checks++; if (o_state !== 2'd2) begin failures++; $display("[TB] FAIL unlock_state: got %0d expected 2", o_state); end
    checks++; if (o_locked !== 1'b0) begin failures++; $display("[TB] FAIL unlock_flag: got %0d expected 0", o_locked); end
    checks++; if (o_fb_ON !== 32'd1) begin failures++; $display("[TB] FAIL unlock_fb_on: got %0d expected 1", o_fb_ON); end
    go_to(614);
    checks++; if (o_gain_sel !== 32'd3) begin failures++; $display("[TB] FAIL unlock_gain: got %0d expected 3", o_gain_sel); end
  endtask

  // ofs=120 with P=100 loads at the wrap at edge 650: no strobes and a
  // sticky o_cfg_err; then an asynchronous reset between clock edges.
  task automatic test_cfg_err_and_reset();
    int n;
    i_period = 16'd100; i_trig_ofs = 16'd120; i_err = 32'd5000;
    go_to(640);
    checks++; if (o_cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL cfg_err_early: got %0d expected 0", o_cfg_err); end
    go_to(652);
    checks++; if (o_cfg_err !== 1'b1) begin failures++; $display("[TB] FAIL cfg_err_set: got %0d expected 1", o_cfg_err); end
    i_trig_ofs = 16'd10;
    n = 0;
    while (cyc < 749) begin tick(); n += int'(o_trig | o_trig_dly); end
    checks++; if (n != 0) begin failures++; $display("[TB] FAIL cfg_no_strobes: got %0d pulses expected 0", n); end
    go_to(761);
    checks++; if (o_trig !== 1'b1) begin failures++; $display("[TB] FAIL cfg_fixed_trig: got %0d expected 1", o_trig); end
    go_to(770);
    checks++; if (o_cfg_err !== 1'b1) begin failures++; $display("[TB] FAIL cfg_err_sticky: got %0d expected 1", o_cfg_err); end
    go_to(780);
    #3;
    i_rst_n = 1'b0;
    #1;
    checks++; if (o_state !== 2'd0) begin failures++; $display("[TB] FAIL async_state: got %0d expected 0", o_state); end
    checks++; if (o_fb_ON !== 32'd0) begin failures++; $display("[TB] FAIL async_fb_on: got %0d expected 0", o_fb_ON); end
    checks++; if (o_gain_sel !== 32'd5) begin failures++; $display("[TB] FAIL async_gain: got %0d expected 5", o_gain_sel); end
    checks++; if (o_cfg_err !== 1'b0) begin failures++; $display("[TB] FAIL async_cfg_err: got %0d expected 0", o_cfg_err); end
    checks++; if ({o_trig, o_trig_dly, o_locked, o_fault} !== 4'b0000) begin failures++; $display("[TB] FAIL async_flags: got %b expected 0000", {o_trig, o_trig_dly, o_locked, o_fault}); end
  endtask

  // P=20, ofs=2, error never in window. ACQ from edge 20; ACQ trigs at
  // 23,43,...,163. With the timeout, the 8th sets o_fault and the wrap at
  // 180 falls back to CONST; without it, ACQ persists.
  task automatic test_timeout();
    i_period = 16'd20; i_trig_ofs = 16'd2; i_mode = 2'd1; i_err = 32'h7FFF_FFFF;
    release_reset();
    go_to(163);
    checks++; if (o_fault !== 1'b0) begin failures++; $display("[TB] FAIL to_fault_early: got %0d expected 0", o_fault); end
    checks++; if (o_state !== 2'd2) begin failures++; $display("[TB] FAIL to_state_acq: got %0d expected 2", o_state); end
    go_to(164);
`ifdef FB_SEQ_TIMEOUT_EN
    checks++; if (o_fault !== 1'b1) begin failures++; $display("[TB] FAIL to_fault_set: got %0d expected 1", o_fault); end
`else
    checks++; if (o_fault !== 1'b0) begin failures++; $display("[TB] FAIL to_fault_off: got %0d expected 0", o_fault); end
`endif
    go_to(179);
    checks++; if (o_state !== 2'd2) begin failures++; $display("[TB] FAIL to_pre_wrap: got %0d expected 2", o_state); end
    go_to(180);
`ifdef FB_SEQ_TIMEOUT_EN
    checks++; if (o_state !== 2'd1) begin failures++; $display("[TB] FAIL to_const_state: got %0d expected 1", o_state); end
    checks++; if (o_fb_ON !== 32'd2) begin failures++; $display("[TB] FAIL to_const_fb_on: got %0d expected 2", o_fb_ON); end
`else
    checks++; if (o_state !== 2'd2) begin failures++; $display("[TB] FAIL to_acq_kept: got %0d expected 2", o_state); end
    checks++; if (o_fb_ON !== 32'd1) begin failures++; $display("[TB] FAIL to_acq_fb_on: got %0d expected 1", o_fb_ON); end
`endif
    go_to(181);
    i_mode = 2'd0;
    go_to(182);
    checks++; if (o_fault !== 1'b0) begin failures++; $display("[TB] FAIL to_fault_clear: got %0d expected 0", o_fault); end
    go_to(200);
    checks++; if (o_state !== 2'd0) begin failures++; $display("[TB] FAIL to_idle: got %0d expected 0", o_state); end
  endtask

  initial begin
    test_reset();
    test_strobes();
    test_mode_enter();
    test_lock();
    test_unlock();
    test_cfg_err_and_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
